load_store_unit: RTL and testbench

Data-side memory access stage between the CPU32 core and the data Memory. It accepts one load or store request at a time and issues byte, halfword or word accesses to the synchronous-read Memory. Load results are sign- or zero-extended, and completion is returned to the core with a one-cycle response strobe. An optional sequencer splits misaligned accesses into consecutive byte accesses.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// master: core + memory side (drives req_*, mem_data_in); slave: the LSU.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [3:0]  mem_width;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata,
        output mem_data_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_address, mem_width, mem_write, mem_data_out
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata,
        input  mem_data_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_address, mem_width, mem_write, mem_data_out
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-side load/store stage: one request at a time, byte/half/word
// accesses to a synchronous-read memory, extended load data returned
// with a one-cycle rsp_valid strobe.
// Ports: clock, reset_n (async, active low), bus (load_store_unit_if.slave).
// Option: LSU_MISALIGNED_EN splits misaligned LH/LHU/LW/SH/SW into
// consecutive byte accesses; when undefined they complete with rsp_error.
module load_store_unit (
    input  logic clock,
    input  logic reset_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic [31:0] mem_address_q;
    logic [3:0]  mem_width_q;
    logic        mem_write_q;
    logic [31:0] mem_data_q;

    logic        l_write;
    logic [2:0]  l_f3;
    logic [31:0] l_wdata;
    logic        l_bad;

    logic [2:0]  f3;
    logic        legal_f3;
    logic        aligned;
    logic        bad;
    logic [3:0]  acc_w;
    logic [31:0] load_word;

`ifdef LSU_MISALIGNED_EN
    logic        split;
    logic        l_split;
    logic [1:0]  idx_q;
    logic [1:0]  lane_q;
    logic        pend_q;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [1:0]  last_idx;
    logic [1:0]  nxt_idx;
`endif

    function automatic logic [31:0] extend(
        input logic [2:0]  fn,
        input logic [31:0] d
    );
        case (fn)
            3'd0:    extend = {{24{d[7]}}, d[7:0]};
            3'd1:    extend = {{16{d[15]}}, d[15:0]};
            3'd4:    extend = {24'd0, d[7:0]};
            3'd5:    extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        f3 = bus.req_funct3;
        if (bus.req_write)
            legal_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else
            legal_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
                    || (f3 == 3'd4) || (f3 == 3'd5);
        aligned = (f3[1:0] == 2'd0)
               || (f3[1:0] == 2'd1 && !bus.req_address[0])
               || (f3[1:0] == 2'd2 && bus.req_address[1:0] == 2'd0);
        acc_w = 4'd0;
        unique case (1'b1)
            f3[1:0] == 2'd0: acc_w = 4'd1;
            f3[1:0] == 2'd1: acc_w = 4'd2;
            default:         acc_w = 4'd4;
        endcase
`ifdef LSU_MISALIGNED_EN
        split = legal_f3 && !aligned;
        bad   = !legal_f3;
`else
        bad   = !legal_f3 || !aligned;
`endif
    end

`ifdef LSU_MISALIGNED_EN
    // The last byte of a split load lands in the same edge that registers
    // the response, so the response is built from the merged value.
    always_comb begin
        asm_next = asm_q;
        if (pend_q)
            asm_next[{lane_q, 3'b000} +: 8] = bus.mem_data_in[7:0];
        last_idx  = (l_f3[1:0] == 2'd1) ? 2'd1 : 2'd3;
        nxt_idx   = idx_q + 2'd1;
        load_word = l_split ? asm_next : bus.mem_data_in;
    end
`else
    assign load_word = bus.mem_data_in;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_error_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_width_q   <= 4'd0;
            mem_write_q   <= 1'b0;
            mem_data_q    <= 32'd0;
            l_write       <= 1'b0;
            l_f3          <= 3'd0;
            l_wdata       <= 32'd0;
            l_bad         <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            l_split       <= 1'b0;
            idx_q         <= 2'd0;
            lane_q        <= 2'd0;
            pend_q        <= 1'b0;
            asm_q         <= 32'd0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            asm_q  <= asm_next;
            pend_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        l_write <= bus.req_write;
                        l_f3    <= f3;
                        l_wdata <= bus.req_wdata;
                        l_bad   <= bad;
                        ready_q <= 1'b0;
                        state_q <= ISSUE;
`ifdef LSU_MISALIGNED_EN
                        l_split <= split;
                        idx_q   <= 2'd0;
                        asm_q   <= 32'd0;
`endif
                        if (!bad) begin
                            mem_address_q <= bus.req_address;
                            mem_write_q   <= bus.req_write;
`ifdef LSU_MISALIGNED_EN
                            if (split) begin
                                mem_width_q <= 4'd1;
                                mem_data_q  <= bus.req_write ?
                                    {24'd0, bus.req_wdata[7:0]} : 32'd0;
                            end else
`endif
                            begin
                                mem_width_q <= acc_w;
                                mem_data_q  <= bus.req_write ?
                                    bus.req_wdata : 32'd0;
                            end
                        end
                    end
                end
                ISSUE: begin
`ifdef LSU_MISALIGNED_EN
                    pend_q <= l_split && !l_write && !l_bad;
                    lane_q <= idx_q;
                    if (l_split && idx_q != last_idx) begin
                        idx_q         <= nxt_idx;
                        mem_address_q <= mem_address_q + 32'd1;
                        mem_data_q    <= l_write ?
                            {24'd0, l_wdata[{nxt_idx, 3'b000} +: 8]} : 32'd0;
                    end else
`endif
                    begin
                        mem_address_q <= 32'd0;
                        mem_width_q   <= 4'd0;
                        mem_write_q   <= 1'b0;
                        mem_data_q    <= 32'd0;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= l_bad;
                    rsp_rdata_q <= (l_bad || l_write) ?
                        32'd0 : extend(l_f3, load_word);
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_width    = mem_width_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_data_out = mem_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
// Covers reset, word/byte/half accesses, illegal, misaligned, throughput.
module tb_load_store_unit;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    load_store_unit_if bus();

    load_store_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    bit [7:0]    mem [256];
    bit          init_done;
    logic [31:0] rd;

    // Synchronous-read memory, addresses folded to 8 bits.
    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            init_done <= 1'b1;
            bus.mem_data_in <= 32'd0;
        end else if (bus.mem_width != 4'd0) begin
            rd = 32'd0;
            for (int i = 0; i < int'(bus.mem_width); i++) begin
                rd[8*i +: 8] = mem[8'(bus.mem_address + 32'(i))];
                if (bus.mem_write)
                    mem[8'(bus.mem_address + 32'(i))]
                        <= bus.mem_data_out[8*i +: 8];
            end
            bus.mem_data_in <= rd;
        end
    end

    // Presents one request at the current negedge and follows it to rsp.
    task automatic run_req(
        input  logic        wr,
        input  logic [2:0]  fn,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output logic [31:0] rdata,
        output logic        err,
        output int          lat,
        output int          nacc,
        output logic [31:0] fa,
        output logic [31:0] la,
        output logic [3:0]  fw,
        output time         t,
        output logic        rdy_bad
    );
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_funct3  = fn;
        bus.req_address = addr;
        bus.req_wdata   = wdata;
        for (int w = 0; w < 20 && !bus.req_ready; w++) @(negedge clock);
        @(posedge clock);
        lat = -1; nacc = 0; fa = '0; la = '0; fw = '0; t = 0;
        rdata = 'x; err = 'x; rdy_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 0) bus.req_valid = 1'b0;
            if (bus.mem_width != 4'd0) begin
                if (nacc == 0) begin
                    fa = bus.mem_address;
                    fw = bus.mem_width;
                end
                la = bus.mem_address;
                nacc++;
            end
            if (bus.rsp_valid) begin
                lat = c; rdata = bus.rsp_rdata; err = bus.rsp_error;
                t = $time;
                if (!bus.req_ready) rdy_bad = 1'b1;
                break;
            end
            if (bus.req_ready) rdy_bad = 1'b1;
        end
    endtask

    logic [31:0] rdata, fa, la;
    logic        err, rb;
    logic [3:0]  fw;
    int          lat, nacc;
    time         t1, t2, t3;

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'd0) begin errors++;
            $display("FAIL rst_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++;
            $display("FAIL rst_error got %b want 0", bus.rsp_error); end
        checks++; if ({bus.mem_address, bus.mem_width, bus.mem_write,
                       bus.mem_data_out} !== 69'd0) begin errors++;
            $display("FAIL rst_mem got %h/%h/%b/%h want 0", bus.mem_address,
                     bus.mem_width, bus.mem_write, bus.mem_data_out); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_word();
        run_req(1, 3'd2, 32'h80, 32'hDEADBEEF, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (lat !== 2 || nacc !== 1 || fw !== 4'd4) begin errors++;
            $display("FAIL sw_timing got lat %0d nacc %0d w %0d want 2 1 4",
                     lat, nacc, fw); end
        checks++; if (rdata !== 32'd0 || err !== 1'b0 || rb) begin errors++;
            $display("FAIL sw_rsp got %h %b rb %b want 0 0 0",
                     rdata, err, rb); end
        run_req(0, 3'd2, 32'h80, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (lat !== 2 || nacc !== 1 || fw !== 4'd4
                      || fa !== 32'h80) begin errors++;
            $display("FAIL lw_timing got lat %0d nacc %0d w %0d a %h",
                     lat, nacc, fw, fa); end
        checks++; if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL lw_data got %h %b want deadbeef 0", rdata, err);
        end
    endtask

    task automatic test_byte();
        run_req(1, 3'd0, 32'h85, 32'h000000F0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 1 || fw !== 4'd1 || lat !== 2) begin
            errors++;
            $display("FAIL sb_acc got nacc %0d w %0d lat %0d", nacc, fw, lat);
        end
        run_req(0, 3'd0, 32'h85, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'hFFFFFFF0) begin errors++;
            $display("FAIL lb got %h want fffffff0", rdata); end
        run_req(0, 3'd4, 32'h85, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h000000F0) begin errors++;
            $display("FAIL lbu got %h want 000000f0", rdata); end
        run_req(0, 3'd4, 32'h84, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h00000084) begin errors++;
            $display("FAIL lbu_84 got %h want 00000084", rdata); end
        run_req(0, 3'd0, 32'h86, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'hFFFFFF86) begin errors++;
            $display("FAIL lb_86 got %h want ffffff86", rdata); end
    endtask

    task automatic test_half();
        run_req(1, 3'd1, 32'h90, 32'h00008001, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 1 || fw !== 4'd2) begin errors++;
            $display("FAIL sh_acc got nacc %0d w %0d want 1 2", nacc, fw); end
        run_req(0, 3'd1, 32'h90, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'hFFFF8001) begin errors++;
            $display("FAIL lh got %h want ffff8001", rdata); end
        run_req(0, 3'd5, 32'h90, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h00008001) begin errors++;
            $display("FAIL lhu got %h want 00008001", rdata); end
    endtask

`ifdef LSU_MISALIGNED_EN
    task automatic test_misaligned();
        run_req(1, 3'd2, 32'hA1, 32'h11223344, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 4 || fa !== 32'hA1 || la !== 32'hA4
                      || fw !== 4'd1 || lat !== 5) begin errors++;
            $display("FAIL msw got n %0d %h..%h w %0d lat %0d", nacc, fa,
                     la, fw, lat); end
        run_req(0, 3'd2, 32'hA1, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h11223344 || lat !== 5 || err) begin
            errors++;
            $display("FAIL mlw got %h lat %0d err %b want 11223344 5 0",
                     rdata, lat, err); end
        run_req(0, 3'd4, 32'hA1, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h00000044) begin errors++;
            $display("FAIL mlbu got %h want 00000044", rdata); end
        run_req(0, 3'd1, 32'h91, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'hFFFF9280 || lat !== 3 || nacc !== 2)
        begin errors++;
            $display("FAIL mlh got %h lat %0d n %0d want ffff9280 3 2",
                     rdata, lat, nacc); end
        run_req(0, 3'd2, 32'hFFFFFFFF, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h020100FF || fa !== 32'hFFFFFFFF
                      || la !== 32'h00000002) begin errors++;
            $display("FAIL mwrap got %h %h..%h want 020100ff", rdata, fa, la);
        end
    endtask
`else
    task automatic test_misaligned();
        run_req(0, 3'd1, 32'h91, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 0 || err !== 1'b1 || rdata !== 32'd0
                      || lat !== 2) begin errors++;
            $display("FAIL mis_lh got n %0d err %b %h lat %0d want 0 1 0 2",
                     nacc, err, rdata, lat); end
        run_req(1, 3'd2, 32'h82, 32'h12345678, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 0 || err !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL mis_sw got n %0d err %b lat %0d want 0 1 2",
                     nacc, err, lat); end
    endtask
`endif

    task automatic test_illegal();
        run_req(0, 3'd3, 32'h80, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 0 || err !== 1'b1 || rdata !== 32'd0
                      || lat !== 2) begin errors++;
            $display("FAIL ill_ld3 got n %0d err %b %h lat %0d want 0 1 0 2",
                     nacc, err, rdata, lat); end
        run_req(0, 3'd6, 32'h80, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 0 || err !== 1'b1) begin errors++;
            $display("FAIL ill_ld6 got n %0d err %b want 0 1", nacc, err); end
        run_req(1, 3'd4, 32'h80, 32'h55555555, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (nacc !== 0 || err !== 1'b1 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL ill_st4 got n %0d err %b %h want 0 1 0",
                     nacc, err, rdata); end
        run_req(0, 3'd2, 32'h80, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL ill_after got %h %b want deadbeef 0", rdata, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        run_req(0, 3'd2, 32'h80, 32'h0, d1, err, lat, nacc,
                fa, la, fw, t1, rb);
        run_req(0, 3'd4, 32'h85, 32'h0, d2, err, lat, nacc,
                fa, la, fw, t2, rb);
        run_req(0, 3'd5, 32'h90, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t3, rb);
        checks++; if (t2 - t1 !== 30 || t3 - t2 !== 30) begin errors++;
            $display("FAIL b2b_rate got %0t %0t want 30 30", t2 - t1,
                     t3 - t2); end
        checks++; if (d1 !== 32'hDEADBEEF || d2 !== 32'h000000F0
                      || rdata !== 32'h00008001) begin errors++;
            $display("FAIL b2b_data got %h %h %h", d1, d2, rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, tgt;
        logic        hit;
`ifdef LSU_MISALIGNED_EN
        a = 32'hB1; tgt = 32'hB3;
`else
        a = 32'hB0; tgt = 32'hB0;
`endif
        hit = 1'b0;
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_funct3  = 3'd2;
        bus.req_address = a;
        bus.req_wdata   = 32'hAABBCCDD;
        @(posedge clock);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            if (bus.mem_width != 4'd0 && bus.mem_address == tgt) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++;
            $display("FAIL rmid_reach got 0 want 1"); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_width !== 4'd0 || bus.mem_address !== 32'd0
                      || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
        begin errors++;
            $display("FAIL rmid_out got w %h a %h rdy %b v %b", bus.mem_width,
                     bus.mem_address, bus.req_ready, bus.rsp_valid); end
        @(negedge clock);
        reset_n = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (bus.rsp_valid) hit = 1'b1;
        end
        checks++; if (hit) begin errors++;
            $display("FAIL rmid_norsp got 1 want 0"); end
        run_req(0, 3'd2, 32'h80, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'hDEADBEEF || lat !== 2 || err) begin
            errors++;
            $display("FAIL rmid_lw got %h lat %0d err %b want deadbeef 2 0",
                     rdata, lat, err); end
        run_req(0, 3'd4, 32'hB4, 32'h0, rdata, err, lat, nacc,
                fa, la, fw, t1, rb);
        checks++; if (rdata !== 32'h000000B4) begin errors++;
            $display("FAIL rmid_b4 got %h want 000000b4", rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_address = 32'd0;
        bus.req_wdata   = 32'd0;
        @(negedge clock);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
